// File: rtl/ber_checker.sv
// rtl/ber_checker.sv - PRBS bit-error-rate checker with automatic TX-to-RX delay search
module ber_checker #(
    parameter int OS          = 4,
    parameter int IW          = 8,
    parameter int PRBS_LEN    = 511,
    parameter int DW          = 9,
    parameter int SEARCH_BITS = 511,
    parameter int LOL_THRESH  = 32,
    parameter int CW          = 64
) (
    input  logic                    clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic [$clog2(OS)-1:0]   i_offset,
    input  logic [IW-1:0]           i_sample,
    input  logic                    i_ref_bit,
    input  logic                    i_ref_valid,
    output logic                    o_locked,
    output logic [DW-1:0]           o_delay,
    output logic [CW-1:0]           o_bit_count,
    output logic [CW-1:0]           o_err_count,
    output logic                    o_ber_zero
);

    localparam int PW  = $clog2(OS);
    localparam int WW1 = $clog2(SEARCH_BITS + 1);
    localparam int WW2 = $clog2(LOL_THRESH + 1);
    localparam int WW  = (WW1 > WW2) ? WW1 : WW2;

    typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

    state_t          state, state_n;
    logic [DW-1:0]   wr_ptr, delay, delay_n, next_delay, rd_idx;
    logic [PW-1:0]   phase, offset_q;
    logic            ref_mem [2**DW];
    logic            strobe, off_chg, rx_bit, cmp_v, cmp_err;
    logic [WW-1:0]   win_cnt, win_cnt_n, win_err, win_err_n, wc_inc, we_inc;
    logic [CW-1:0]   bit_cnt, bit_cnt_n, err_cnt, err_cnt_n;
    logic            sample_unused;

    assign sample_unused = &{1'b0, i_sample[IW-2:0]};
    assign rx_bit        = ~i_sample[IW-1];
    assign off_chg       = i_enable && (i_offset != offset_q);
    // Strobes that would be scored against a stale delay are suppressed.
    assign strobe        = i_enable && (phase == i_offset) && (state != IDLE) && !off_chg;
    // Pointer arithmetic wraps at the buffer depth so any delay below it is exact.
    assign rd_idx        = wr_ptr - DW'(1) - delay;
    assign next_delay    = (delay == DW'(PRBS_LEN - 1)) ? '0 : delay + 1'b1;
    assign wc_inc        = win_cnt + 1'b1;
    assign we_inc        = win_err + WW'(cmp_err);

    always_ff @(posedge clock) begin
        if (i_ref_valid)
            ref_mem[wr_ptr] <= i_ref_bit;
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            phase    <= '0;
            offset_q <= '0;
            cmp_v    <= 1'b0;
            cmp_err  <= 1'b0;
            delay    <= '0;
            win_cnt  <= '0;
            win_err  <= '0;
            bit_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            if (i_ref_valid)
                wr_ptr <= wr_ptr + 1'b1;
            if (i_enable)
                phase <= (phase == PW'(OS - 1)) ? '0 : phase + 1'b1;
            offset_q <= i_offset;
            cmp_v    <= strobe;
            cmp_err  <= rx_bit ^ ref_mem[rd_idx];
            state    <= state_n;
            delay    <= delay_n;
            win_cnt  <= win_cnt_n;
            win_err  <= win_err_n;
            bit_cnt  <= bit_cnt_n;
            err_cnt  <= err_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        delay_n   = delay;
        win_cnt_n = win_cnt;
        win_err_n = win_err;
        bit_cnt_n = bit_cnt;
        err_cnt_n = err_cnt;
        if (!i_enable) begin
            state_n = IDLE;
        end else if (state == IDLE || off_chg) begin
            state_n   = SEARCH;
            delay_n   = '0;
            win_cnt_n = '0;
            win_err_n = '0;
            bit_cnt_n = '0;
            err_cnt_n = '0;
        end else if (cmp_v) begin
            case (state)
                SEARCH: begin
                    if (wc_inc == WW'(SEARCH_BITS)) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                        if (we_inc == '0) begin
                            state_n   = LOCKED;
                            bit_cnt_n = '0;
                            err_cnt_n = '0;
                        end else begin
                            delay_n = next_delay;
                        end
                    end else begin
                        win_cnt_n = wc_inc;
                        win_err_n = we_inc;
                    end
                end
                LOCKED: begin
                    if (!(&bit_cnt))
                        bit_cnt_n = bit_cnt + 1'b1;
                    if (cmp_err && !(&err_cnt))
                        err_cnt_n = err_cnt + 1'b1;
                    // Loss of lock wins over a window boundary in the same cycle.
                    if (we_inc >= WW'(LOL_THRESH)) begin
                        state_n   = SEARCH;
                        delay_n   = next_delay;
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else if (wc_inc == WW'(SEARCH_BITS)) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else begin
                        win_cnt_n = wc_inc;
                        win_err_n = we_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_locked    = (state == LOCKED);
    assign o_delay     = delay;
    assign o_bit_count = bit_cnt;
    assign o_err_count = err_cnt;
    assign o_ber_zero  = o_locked && (err_cnt == '0);

endmodule
